// File: rtl/cyq_kscan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package cyq_kscan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    EVAL   = 2'd3
  } kscan_state_e;

  localparam int          ROWS     = 4;
  localparam int          COLS     = 4;
  localparam int          CODE_W   = 4;
  localparam logic [3:0]  ROW_IDLE = 4'hF;

endpackage

// File: rtl/cyq_kscan_debounce.sv
// Per-scan debounce and key presentation: tracks the candidate key, counts
// consecutive matching scans (press) and empty scans (release), reports a
// held key once, and owns the KeyValid/KeyCode holding register plus the
// overrun pulse when a freshly accepted key finds the register still full.
module cyq_kscan_debounce
  import cyq_kscan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eval,
  input  logic              hit,
  input  logic              multi,
  input  logic [CODE_W-1:0] code,
  input  logic              ack,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              overrun
);

  localparam int             CW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  DMAX = CW'(DEBOUNCE_SCANS);

  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CW-1:0]     stable_q, stable_d;
  logic [CW-1:0]     rel_q, rel_d;
  logic              rep_q, rep_d;
  logic              eff_hit;
  logic              accept;
  logic              retire;

  // Next-state of the debounce counters, evaluated only on the EVAL strobe.
  // A scan flagged as multi (ghosting reject) counts as an empty scan.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    rel_d    = rel_q;
    rep_d    = rep_q;
    accept   = 1'b0;
    eff_hit  = hit & ~multi;
    if (eval) begin
      if (eff_hit) begin
        rel_d = '0;
        if (code == cand_q) begin
          stable_d = (stable_q == DMAX) ? DMAX : stable_q + 1'b1;
        end else begin
          // A different key starts its own debounce and may be reported
          // even though the previous one was never released.
          cand_d   = code;
          stable_d = CW'(1);
          rep_d    = 1'b0;
        end
      end else begin
        stable_d = '0;
        rel_d    = (rel_q == DMAX) ? DMAX : rel_q + 1'b1;
        if (rel_d == DMAX) rep_d = 1'b0;
      end
      if ((stable_d == DMAX) && !rep_q) begin
        accept = 1'b1;
        rep_d  = 1'b1;
      end
    end
  end

  assign retire = key_valid & ack;

  // Counter registers and the key holding register; an ack in the accept
  // cycle frees the register so the new key loads without overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q    <= '0;
      stable_q  <= '0;
      rel_q     <= '0;
      rep_q     <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      rel_q    <= rel_d;
      rep_q    <= rep_d;
      overrun  <= 1'b0;
      if (accept && (!key_valid || retire)) begin
        key_code  <= cand_d;
        key_valid <= 1'b1;
      end else begin
        if (accept) overrun   <= 1'b1;
        if (retire) key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cyq_keypad_scan.sv
// 4x4 active-low keypad scan controller. Walks every (row, col) position
// through the row decoder and column mux, samples one bit per position and
// hands a per-scan summary to the debounce block.
// Optional build macro CYQ_KSCAN_MULTI_REJECT_EN: scans with more than one
// pressed key are rejected as ghosting and pulse Multi; otherwise the first
// key in scan order wins and Multi is tied low.
//
// Handshake: KeyValid rises with KeyCode and both hold until a cycle with
// KeyValid=1 and KeyAck=1; KeyValid falls on the following edge. KeyAck
// while KeyValid=0 has no effect.
module cyq_keypad_scan
  import cyq_kscan_pkg::*;
#(
  parameter int SETTLE_CYC     = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  output logic [3:0]        RowCode,
  output logic [1:0]        ColSel,
  output logic              MuxE,
  input  logic              ColData,
  output logic [CODE_W-1:0] KeyCode,
  output logic              KeyValid,
  input  logic              KeyAck,
  output logic              Overrun,
  output logic              Multi,
  output kscan_state_e      dbg_state
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  kscan_state_e      state_q, state_d;
  logic [1:0]        row_q, col_q;
  logic [SW-1:0]     settle_q;
  logic              settle_done;
  logic              last_pos;
  logic              hit_q;
  logic [CODE_W-1:0] code_q;
  logic              ghost;

  assign settle_done = (settle_q == SW'(SETTLE_CYC - 1));
  assign last_pos    = (row_q == 2'(ROWS - 1)) && (col_q == 2'(COLS - 1));
  assign dbg_state   = state_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and matrix drive; the row and mux are only driven while a
  // position is settling or being sampled.
  always_comb begin
    state_d = state_q;
    RowCode = ROW_IDLE;
    MuxE    = 1'b1;
    ColSel  = col_q;
    case (state_q)
      IDLE: begin
        if (Enable) state_d = SETTLE;
      end
      SETTLE: begin
        MuxE    = 1'b0;
        RowCode = {2'b00, row_q};
        if (settle_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        MuxE    = 1'b0;
        RowCode = {2'b00, row_q};
        state_d = last_pos ? EVAL : SETTLE;
      end
      EVAL: begin
        state_d = Enable ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CYQ_KSCAN_MULTI_REJECT_EN
  logic multi_q;
  assign ghost = multi_q;
  assign Multi = (state_q == EVAL) & multi_q;
`else
  assign ghost = 1'b0;
  assign Multi = 1'b0;
`endif

  // Scan datapath: settle timer, position counter and per-scan hit summary.
  // {row,col} increments as one 4-bit value so a column wrap carries into
  // the row and the last position wraps back to (0,0) for the next scan.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q    <= '0;
      col_q    <= '0;
      settle_q <= '0;
      hit_q    <= 1'b0;
      code_q   <= '0;
`ifdef CYQ_KSCAN_MULTI_REJECT_EN
      multi_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          row_q    <= '0;
          col_q    <= '0;
          settle_q <= '0;
          hit_q    <= 1'b0;
`ifdef CYQ_KSCAN_MULTI_REJECT_EN
          multi_q  <= 1'b0;
`endif
        end
        SETTLE: begin
          settle_q <= settle_done ? '0 : settle_q + 1'b1;
        end
        SAMPLE: begin
          if (!ColData && !hit_q) begin
            hit_q  <= 1'b1;
            code_q <= {row_q, col_q};
          end
`ifdef CYQ_KSCAN_MULTI_REJECT_EN
          if (!ColData && hit_q) multi_q <= 1'b1;
`endif
          {row_q, col_q} <= {row_q, col_q} + 4'd1;
        end
        EVAL: begin
          settle_q <= '0;
          hit_q    <= 1'b0;
`ifdef CYQ_KSCAN_MULTI_REJECT_EN
          multi_q  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  cyq_kscan_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (CLK),
    .rst      (RST),
    .eval     (state_q == EVAL),
    .hit      (hit_q),
    .multi    (ghost),
    .code     (code_q),
    .ack      (KeyAck),
    .key_code (KeyCode),
    .key_valid(KeyValid),
    .overrun  (Overrun)
  );

endmodule

// File: tb/tb_cyq_keypad_scan.sv
// Bench for cyq_keypad_scan: key-matrix model on ColData, scan-level
// reference model, scoreboard queue of expected key codes popped by a
// monitor on every KeyValid&KeyAck cycle.
module tb_cyq_keypad_scan;
  import cyq_kscan_pkg::*;

  localparam int DS = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         CLK = 1'b0;
  logic         RST;
  logic         Enable;
  logic         ColData;
  logic         KeyAck;
  logic [3:0]   RowCode;
  logic [1:0]   ColSel;
  logic         MuxE;
  logic [3:0]   KeyCode;
  logic         KeyValid;
  logic         Overrun;
  logic         Multi;
  kscan_state_e dbg_state;

  always #5 CLK = ~CLK;

  cyq_keypad_scan #(.SETTLE_CYC(2), .DEBOUNCE_SCANS(DS)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .RowCode(RowCode),
    .ColSel(ColSel), .MuxE(MuxE), .ColData(ColData), .KeyCode(KeyCode),
    .KeyValid(KeyValid), .KeyAck(KeyAck), .Overrun(Overrun),
    .Multi(Multi), .dbg_state(dbg_state)
  );

  // Key matrix: pressed keys pull the selected column low; the mux output
  // is random noise while disabled.
  logic [15:0] mask;
  logic        noise;
  always @(posedge CLK) noise <= 1'($urandom_range(0, 1));
  assign ColData = MuxE ? noise
                        : ~((RowCode[3:2] == 2'b00) && mask[{RowCode[1:0], ColSel}]);

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  int         ovr_seen = 0;
  int         multi_seen = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake retires the oldest expected key.
  always @(negedge CLK) begin
    if (!RST) begin
      if (Overrun) ovr_seen++;
      if (Multi) multi_seen++;
      if (KeyValid && KeyAck) begin
        if (exp_q.size() == 0) check("unexpected_key", int'(KeyCode), -1);
        else check("key_code_handshake", int'(KeyCode), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- reference model (per full scan) ----------------
  int         hist[$];
  int         last_hit;
  bit         reported;
  bit         pend;
  logic [3:0] pend_code;
  int         exp_ovr = 0;
  int         exp_multi = 0;

  task automatic model_reset();
    hist.delete();
    last_hit  = -1;
    reported  = 1'b0;
    pend      = 1'b0;
    pend_code = '0;
    exp_q.delete();
  endtask

  // One scan's outcome: result r is the first pressed key in row-major
  // order, or -1 for none. A key is accepted once the last DS scan results
  // are all that key and it has not been reported since it (re)appeared.
  task automatic model_scan(input logic [15:0] m, input bit ack_eval);
    int first, cnt, r;
    bit same, none;
    first = -1;
    cnt   = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    r = first;
`ifdef CYQ_KSCAN_MULTI_REJECT_EN
    if (cnt > 1) begin
      r = -1;
      exp_multi++;
    end
`endif
    if (ack_eval && pend) pend = 1'b0;
    hist.push_back(r);
    if (hist.size() > DS) void'(hist.pop_front());
    if (r >= 0 && r != last_hit) reported = 1'b0;
    if (r >= 0) last_hit = r;
    same = (hist.size() == DS);
    none = same;
    foreach (hist[i]) begin
      if (hist[i] != r)  same = 1'b0;
      if (hist[i] != -1) none = 1'b0;
    end
    if (none) reported = 1'b0;
    if (same && r >= 0 && !reported) begin
      reported = 1'b1;
      if (pend) exp_ovr++;
      else begin
        pend      = 1'b1;
        pend_code = 4'(r);
        exp_q.push_back(4'(r));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkpoint();
    @(negedge CLK);
    check("key_valid", int'(KeyValid), int'(pend));
    if (pend) check("key_code", int'(KeyCode), int'(pend_code));
    check("state_idle", int'(dbg_state), int'(IDLE));
  endtask

  // Exactly one scan: Enable pulses for one cycle from IDLE. With ack_eval,
  // KeyAck is high only during the EVAL cycle (48 cycles after SETTLE entry).
  task automatic do_scan(input logic [15:0] m, input bit ack_eval);
    tick();
    mask   = m;
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    if (ack_eval) begin
      repeat (48) @(posedge CLK);
      #1 KeyAck = 1'b1;
      tick();
      KeyAck = 1'b0;
      repeat (12) tick();
    end else begin
      repeat (60) tick();
    end
    model_scan(m, ack_eval);
    checkpoint();
  endtask

  task automatic do_ack();
    tick();
    KeyAck = 1'b1;
    tick();
    KeyAck = 1'b0;
    if (pend) pend = 1'b0;
    @(negedge CLK);
    check("key_valid_after_ack", int'(KeyValid), 0);
  endtask

  task automatic scans(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) do_scan(m, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_ovr, base_multi, run_left, m_sel;
    logic [15:0] cur;
    RST    = 1'b1;
    Enable = 1'b0;
    KeyAck = 1'b0;
    mask   = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_rowcode", int'(RowCode), 15);
    check("rst_colsel", int'(ColSel), 0);
    check("rst_muxe", int'(MuxE), 1);
    check("rst_keycode", int'(KeyCode), 0);
    check("rst_keyvalid", int'(KeyValid), 0);
    check("rst_overrun", int'(Overrun), 0);
    check("rst_multi", int'(Multi), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));

    // Continuous scanning, no key: 3 cycles per position, 49-cycle period.
    tick();
    RST    = 1'b0;
    Enable = 1'b1;
    @(posedge CLK);
    for (int n = 0; n < 98; n++) begin
      int ph;
      @(negedge CLK);
      ph = n % 49;
      if (ph < 48) begin
        check("scan_row", int'(RowCode), (ph / 3) / 4);
        check("scan_col", int'(ColSel), (ph / 3) % 4);
        check("scan_muxe", int'(MuxE), 0);
      end else begin
        check("scan_eval", int'(dbg_state), int'(EVAL));
        check("scan_keyvalid", int'(KeyValid), 0);
      end
      if (n == 97) Enable = 1'b0;
    end
    repeat (5) tick();
    model_scan('0, 1'b0);
    model_scan('0, 1'b0);
    @(negedge CLK);
    check("enable_drop_idle", int'(dbg_state), int'(IDLE));

    // Key 6 held four scans: reported once, holds without ack.
    scans(16'(1) << 6, 4);
    check("k6_valid", int'(KeyValid), 1);
    check("k6_code", int'(KeyCode), 6);
    repeat (10) tick();
    @(negedge CLK);
    check("k6_hold_valid", int'(KeyValid), 1);
    check("k6_hold_code", int'(KeyCode), 6);
    do_ack();
    scans(16'(1) << 6, 3);
    check("k6_no_repeat", int'(KeyValid), 0);
    scans('0, 4);

    // Key 6 for only three scans never reports.
    scans(16'(1) << 6, 3);
    scans('0, 4);
    check("k6_short", int'(KeyValid), 0);

    // Key 9 unacked, then key 3 debounced: one overrun, code stays 9.
    base_ovr = ovr_seen;
    scans(16'(1) << 9, 4);
    scans('0, 4);
    scans(16'(1) << 3, 4);
    check("ovr_count", ovr_seen - base_ovr, 1);
    check("ovr_keycode", int'(KeyCode), 9);
    do_ack();
    scans('0, 4);

    // Keys 2 and 13 together.
    base_multi = multi_seen;
    scans((16'(1) << 2) | (16'(1) << 13), 4);
`ifdef CYQ_KSCAN_MULTI_REJECT_EN
    check("multi_pulses", multi_seen - base_multi, 4);
    check("multi_no_key", int'(KeyValid), 0);
`else
    check("multi_pulses", multi_seen - base_multi, 0);
    check("multi_first_key", int'(KeyCode), 2);
`endif
    if (pend) do_ack();
    scans('0, 4);

    // Accept and ack in the same cycle: old key retired, new key loaded.
    base_ovr = ovr_seen;
    scans(16'(1) << 7, 4);
    scans('0, 4);
    scans(16'(1) << 11, 3);
    do_scan(16'(1) << 11, 1'b1);
    check("same_cycle_code", int'(KeyCode), 11);
    check("same_cycle_valid", int'(KeyValid), 1);
    check("same_cycle_no_ovr", ovr_seen - base_ovr, 0);
    do_ack();
    scans('0, 4);

    // Reset mid-SETTLE with a pending key.
    scans(16'(1) << 5, 4);
    tick();
    mask   = '0;
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    tick();
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("mid_rst_rowcode", int'(RowCode), 15);
    check("mid_rst_muxe", int'(MuxE), 1);
    check("mid_rst_keyvalid", int'(KeyValid), 0);
    check("mid_rst_state", int'(dbg_state), int'(IDLE));
    tick();
    RST = 1'b0;
    model_reset();

    // Randomized held-key runs with random acks.
    run_left = 0;
    cur      = '0;
    for (int s = 0; s < 60; s++) begin
      if (run_left == 0) begin
        m_sel = $urandom_range(0, 9);
        if (m_sel < 4)      cur = '0;
        else if (m_sel < 8) cur = 16'(1) << $urandom_range(0, 15);
        else cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        run_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 3) == 0) do_ack();
      do_scan(cur, $urandom_range(0, 5) == 0);
      run_left--;
    end
    scans('0, 4);
    if (pend) do_ack();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_overruns", ovr_seen, exp_ovr);
    check("final_multi", multi_seen, exp_multi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
